// File: rtl/sdram_arbiter.sv
// Two-port arbiter serializing instruction (port 0) and data (port 1) requests onto one SDRAM controller.
// Optional macro SDRAM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise port 1 wins ties.
module sdram_arbiter #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data,
    input  logic              p0_we,
    output logic              p0_ack,
    output logic [LINE_W-1:0] p0_q,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    input  logic              p1_we,
    output logic              p1_ack,
    output logic [LINE_W-1:0] p1_q,
    output logic [ADDR_W-1:0] sdc_addr,
    output logic [DATA_W-1:0] sdc_data,
    output logic              sdc_we,
    output logic              sdc_start,
    input  logic [LINE_W-1:0] sdc_q,
    input  logic              sdc_ack,
    input  logic              sdc_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   sdc_addr_q, sdc_addr_d;
    logic [DATA_W-1:0]   sdc_data_q, sdc_data_d;
    logic                sdc_we_q, sdc_we_d;
    logic                sdc_start_q, sdc_start_d;
    logic                p0_ack_q, p0_ack_d;
    logic                p1_ack_q, p1_ack_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                win_s;

    // Tie-break selection; a lone requester always wins in either build
    always_comb begin
        win_s = 1'b0;
        if (p0_req && p1_req) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            win_s = ~last_grant_q;
`else
            win_s = 1'b1;
`endif
        end else if (p1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state and next-output computation for the arbitration FSM
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        sdc_addr_d   = sdc_addr_q;
        sdc_data_d   = sdc_data_q;
        sdc_we_d     = sdc_we_q;
        sdc_start_d  = sdc_start_q;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        line_d       = line_q;
        case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    grant_d     = win_s;
                    sdc_addr_d  = win_s ? p1_addr : p0_addr;
                    sdc_data_d  = win_s ? p1_data : p0_data;
                    sdc_we_d    = win_s ? p1_we : p0_we;
                    sdc_start_d = 1'b1;
                    state_d     = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (sdc_ack) begin
                    sdc_start_d = 1'b0;
                    p0_ack_d    = ~grant_q;
                    p1_ack_d    = grant_q;
                    state_d     = S_DONE;
                    // Writes leave the shared read line untouched
                    if (!sdc_we_q) begin
                        line_d = sdc_q;
                    end else begin
                        line_d = line_q;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DONE: begin
                last_grant_d = grant_q;
                state_d      = S_DRAIN;
            end
            S_DRAIN: begin
                if (!sdc_busy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d     = S_IDLE;
                sdc_start_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; last_grant resets to 1 so port 0 takes the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            sdc_addr_q   <= {ADDR_W{1'b0}};
            sdc_data_q   <= {DATA_W{1'b0}};
            sdc_we_q     <= 1'b0;
            sdc_start_q  <= 1'b0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            line_q       <= {LINE_W{1'b0}};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            sdc_addr_q   <= sdc_addr_d;
            sdc_data_q   <= sdc_data_d;
            sdc_we_q     <= sdc_we_d;
            sdc_start_q  <= sdc_start_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            line_q       <= line_d;
        end
    end

    assign sdc_addr  = sdc_addr_q;
    assign sdc_data  = sdc_data_q;
    assign sdc_we    = sdc_we_q;
    assign sdc_start = sdc_start_q;
    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign p0_q      = line_q;
    assign p1_q      = line_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: plays both requesters and the SDRAM controller,
// predicting grants, data and timing from a transaction-level model.
module tb_sdram_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_v [2];
    logic [23:0]  addr_v [2];
    logic [31:0]  data_v [2];
    logic         we_v [2];
    logic         p0_ack, p1_ack;
    logic [255:0] p0_q, p1_q;
    logic [23:0]  sdc_addr;
    logic [31:0]  sdc_data;
    logic         sdc_we, sdc_start;
    logic [255:0] sdc_q = '0;
    logic         sdc_ack = 1'b0;
    logic         sdc_busy = 1'b0;

    int           total = 0;
    int           bad = 0;
    logic [255:0] exp_q;
    int           last_win;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(req_v[0]), .p0_addr(addr_v[0]), .p0_data(data_v[0]), .p0_we(we_v[0]),
        .p0_ack(p0_ack), .p0_q(p0_q),
        .p1_req(req_v[1]), .p1_addr(addr_v[1]), .p1_data(data_v[1]), .p1_we(we_v[1]),
        .p1_ack(p1_ack), .p1_q(p1_q),
        .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we), .sdc_start(sdc_start),
        .sdc_q(sdc_q), .sdc_ack(sdc_ack), .sdc_busy(sdc_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    task automatic raise(input int p, input logic [23:0] a, input logic [31:0] d, input logic w);
        req_v[p] = 1'b1; addr_v[p] = a; data_v[p] = d; we_v[p] = w;
    endtask

    task automatic raise_rand(input int p);
        raise(p, 24'($urandom()), $urandom(), 1'($urandom_range(0, 1)));
    endtask

    // Arbitration rule at request level
    function automatic int predict();
        if (req_v[0] && req_v[1]) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            return (last_win == 1) ? 0 : 1;
`else
            return 1;
`endif
        end else if (req_v[1]) begin
            return 1;
        end else begin
            return 0;
        end
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        sdc_ack = 1'b0; sdc_busy = 1'b0;
        tick(); tick();
        reset = 1'b0;
        exp_q = '0;
        last_win = 1;
    endtask

    // Controller side of one transaction, checking the expected winner end to end
    task automatic serve(input int w, input int busy_cyc, input bit rereq, input int exp_wait, input bit raise_other);
        int           cnt;
        logic [23:0]  a;
        logic [31:0]  d;
        logic         wr;
        logic [255:0] line;
        a = addr_v[w]; d = data_v[w]; wr = we_v[w];
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!sdc_start && cnt < 20);
        total++;
        if (!sdc_start) begin
            bad++;
            $display("FAIL start_timeout: sdc_start=%0b after %0d cycles, required 1", sdc_start, cnt);
            return;
        end
        if (exp_wait >= 0) begin
            total++;
            if (cnt != exp_wait) begin
                bad++;
                $display("FAIL start_latency: got %0d cycles, required %0d", cnt, exp_wait);
            end
        end
        total++;
        if (sdc_addr !== a || sdc_data !== d || sdc_we !== wr) begin
            bad++;
            $display("FAIL cmd_port%0d: addr=%h data=%h we=%b, required addr=%h data=%h we=%b",
                     w, sdc_addr, sdc_data, sdc_we, a, d, wr);
        end
        if (raise_other) raise_rand(1 - w);
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            sdc_busy = 1'b1;
            tick();
            total++;
            if (sdc_start !== 1'b1 || p0_ack !== 1'b0 || p1_ack !== 1'b0) begin
                bad++;
                $display("FAIL start_hold: start=%b acks=%b%b, required start=1 acks=00", sdc_start, p1_ack, p0_ack);
            end
        end
        line = rand_line();
        sdc_q = line;
        sdc_ack = 1'b1;
        sdc_busy = 1'b1;
        if (!wr) exp_q = line;
        tick();
        sdc_ack = 1'b0;
        sdc_q = rand_line();
        sdc_busy = (busy_cyc > 0);
        total++;
        if (sdc_start !== 1'b0 || {p1_ack, p0_ack} !== ((w == 1) ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL ack_port%0d: start=%b acks(p1p0)=%b%b, required start=0 ack only on port %0d",
                     w, sdc_start, p1_ack, p0_ack, w);
        end
        total++;
        if (p0_q !== exp_q || p1_q !== exp_q) begin
            bad++;
            $display("FAIL q_port%0d: p0_q=%h p1_q=%h, required %h", w, p0_q, p1_q, exp_q);
        end
        if (rereq) raise_rand(w);
        else req_v[w] = 1'b0;
        last_win = w;
        for (int i = 0; i < ((busy_cyc > 1) ? busy_cyc : 1); i++) begin
            tick();
            total++;
            if (sdc_start !== 1'b0 || p0_ack !== 1'b0 || p1_ack !== 1'b0) begin
                bad++;
                $display("FAIL drain: start=%b acks=%b%b, required all 0", sdc_start, p1_ack, p0_ack);
            end
        end
        sdc_busy = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (sdc_start !== 1'b0 || sdc_we !== 1'b0 || p0_ack !== 1'b0 || p1_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: start=%b we=%b acks=%b%b, required 0", sdc_start, sdc_we, p1_ack, p0_ack);
        end
        total++;
        if (sdc_addr !== 24'h0 || sdc_data !== 32'h0 || p0_q !== 256'h0 || p1_q !== 256'h0) begin
            bad++;
            $display("FAIL reset_data: addr=%h data=%h q=%h, required 0", sdc_addr, sdc_data, p0_q);
        end
    endtask

    task automatic test_single_read();
        raise(0, 24'h000010, 32'h12345678, 1'b0);
        serve(0, 0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_single_write();
        raise(1, 24'h000020, 32'hDEADBEEF, 1'b1);
        serve(1, 0, 1'b0, 2, 1'b0);
    endtask

    task automatic test_stray_ack();
        tick(); tick();
        sdc_q = rand_line();
        sdc_ack = 1'b1;
        tick();
        sdc_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (p0_ack !== 1'b0 || p1_ack !== 1'b0 || sdc_start !== 1'b0 || p0_q !== exp_q) begin
                bad++;
                $display("FAIL stray_ack: acks=%b%b start=%b q=%h, required 00 0 %h", p1_ack, p0_ack, sdc_start, p0_q, exp_q);
            end
            tick();
        end
    endtask

    task automatic test_tie();
        apply_reset();
        raise_rand(0);
        raise_rand(1);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        serve(0, 0, 1'b1, 1, 1'b0);
        serve(1, 0, 1'b1, 2, 1'b0);
        serve(0, 0, 1'b0, 2, 1'b0);
        serve(1, 0, 1'b0, 2, 1'b0);
`else
        serve(1, 0, 1'b1, 1, 1'b0);
        serve(1, 0, 1'b1, 2, 1'b0);
        serve(1, 0, 1'b0, 2, 1'b0);
        serve(0, 0, 1'b0, 2, 1'b0);
`endif
    endtask

    task automatic test_busy();
        raise_rand(1);
        serve(1, 5, 1'b0, -1, 1'b1);
        serve(0, 0, 1'b0, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            for (int p = 0; p < 2; p++)
                if (!req_v[p] && $urandom_range(0, 1) == 1) raise_rand(p);
            if (!req_v[0] && !req_v[1]) raise_rand(int'($urandom_range(0, 1)));
            serve(predict(), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1, 1'b0);
        end
        for (int n = 0; n < 2; n++)
            if (req_v[0] || req_v[1]) serve(predict(), 0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        raise(0, 24'h000ABC, 32'h0, 1'b0);
        tick(); tick(); tick();
        total++;
        if (sdc_start !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_start: start=%b, required 1", sdc_start);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (sdc_start !== 1'b0 || p0_ack !== 1'b0 || p1_ack !== 1'b0 || sdc_addr !== 24'h0 || p0_q !== 256'h0) begin
            bad++;
            $display("FAIL async_reset: start=%b acks=%b%b addr=%h q=%h, required all 0",
                     sdc_start, p1_ack, p0_ack, sdc_addr, p0_q);
        end
        req_v[0] = 1'b0;
        sdc_ack = 1'b1;
        tick();
        sdc_ack = 1'b0;
        reset = 1'b0;
        exp_q = '0;
        last_win = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (p0_ack !== 1'b0 || p1_ack !== 1'b0 || sdc_start !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_quiet: acks=%b%b start=%b, required 0", p1_ack, p0_ack, sdc_start);
            end
        end
        raise(0, 24'h000010, 32'h0, 1'b0);
        serve(0, 0, 1'b0, 1, 1'b0);
    endtask

    initial begin
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        addr_v[0] = '0; addr_v[1] = '0;
        data_v[0] = '0; data_v[1] = '0;
        we_v[0] = 1'b0; we_v[1] = 1'b0;
        test_reset();
        test_single_read();
        test_single_write();
        test_stray_ack();
        test_tie();
        test_busy();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter that shares the single SDRAM controller between the instruction-side requester (port 0) and the data-side requester (port 1). It sits directly in front of the controller and drives its address, data, write-enable and start inputs. It returns the controller's 256-bit cache line and a per-port completion pulse to the winning requester, so each client sees a private, serialized SDRAM port.

## Interface
- ADDR_W, 24: word address width, equal to the controller's `sdc_addr`.
- DATA_W, 32: write data width.
- LINE_W, 256: read cache-line width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- p0_req / p1_req  in  1  request. Held high, with addr/data/we stable, until the port's ack.
- p0_addr / p1_addr  in  ADDR_W  request address.
- p0_data / p1_data  in  DATA_W  write data.
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_ack / p1_ack  out  1  one-cycle completion pulse.
- p0_q / p1_q  out  LINE_W  last read line. Both ports are driven from one shared register.
- sdc_addr  out  ADDR_W  to controller.
- sdc_data  out  DATA_W  to controller.
- sdc_we  out  1  to controller.
- sdc_start  out  1  to controller. Held high until sdc_ack.
- sdc_q  in  LINE_W  controller read line; valid in the sdc_ack cycle.
- sdc_ack  in  1  controller completion pulse.
- sdc_busy  in  1  controller busy status.

## Operation
- States: IDLE, START, DONE, DRAIN.
- **IDLE**
  - Sample p0_req and p1_req.
  - If either is high, choose a winner and register its addr/data/we into sdc_addr/sdc_data/sdc_we.
  - Record the winner in `grant`, set sdc_start = 1, and go to START.
  - If neither is high, stay in IDLE.
- **START**
  - sdc_start stays high and sdc_* stay stable.
  - On sdc_ack = 1: drop sdc_start, and if sdc_we = 0 capture sdc_q into the q register.
  - Go to DONE.
- **DONE** (exactly one cycle)
  - Assert the granted port's ack; the other port's ack stays 0.
  - Update last_grant and go to DRAIN.
- **DRAIN**
  - Wait until sdc_busy = 0, then go to IDLE.
  - Req is ignored here, which gives the client at least one cycle to drop req after ack.
- Writes never modify the q register.
- The non-granted port's req is held pending. It is never dropped or acknowledged early.
- Arbitration with both requests high in IDLE is set by the macro under Configuration.
- An sdc_ack seen outside START is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - sdc_start, sdc_we, p0_ack and p1_ack are 0.
  - sdc_addr, sdc_data and the q register are 0.
  - last_grant is 1, so port 0 wins the first tie.
- Request to start: req high at IDLE edge N gives sdc_start high from N+1.
- Ack to client: sdc_ack at edge M gives sdc_start low and port ack high at M+1. The port's q is valid from M+1 and held until the next read completes.
- Back-to-back:
  - DRAIN lasts at least one cycle, so the next sdc_start comes no earlier than M+3.
  - If sdc_busy is still high, DRAIN extends until it falls.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately (asynchronous).
  - The in-flight request is abandoned with no ack.
  - The controller is reset from the same signal.

## Configuration
- Macro: `SDRAM_ARB_ROUND_ROBIN_EN`.
- Defined:
  - Round-robin. On a tie, grant the port that is not last_grant.
  - A port that just completed loses the next tie, so neither port starves.
- Undefined:
  - Fixed priority: port 1 (data) always wins a tie.
  - last_grant is still maintained but is not used for arbitration.
- Single-request behaviour is identical in both builds.

## Test plan
- Single read, port 0:
  - Stimulus: p0_req = 1, p0_addr = 24'h000010, p0_we = 0.
  - Response: sdc_start rises next cycle with sdc_addr = 24'h000010. After sdc_ack, p0_ack pulses for exactly one cycle, p0_q equals the controller line, and p1_ack stays 0.
- Single write, port 1:
  - Stimulus: p1_addr = 24'h000020, p1_data = 32'hDEADBEEF, p1_we = 1.
  - Response: sdc_data = 32'hDEADBEEF and sdc_we = 1 while sdc_start is high. p1_ack pulses once, and p1_q is unchanged from its prior value.
- Simultaneous requests from reset:
  - Stimulus: both ports request in the same cycle, with each port re-requesting immediately after its ack.
  - Response with macro: grants go 0, 1, 0, 1.
  - Response without macro: grants go 1, 1, 1 while p1 keeps requesting.
- Busy extension:
  - Stimulus: hold sdc_busy = 1 for 5 cycles after sdc_ack, with a pending p0_req.
  - Response: sdc_start stays 0 until the cycle after sdc_busy falls.
- Reset mid-operation:
  - Stimulus: assert reset while in START.
  - Response: sdc_start and both acks go to 0 immediately, no ack is issued afterwards, and the next request after reset proceeds normally.
- Stray ack:
  - Stimulus: pulse sdc_ack while in IDLE.
  - Response: no port ack and no change to q.
